// File: rtl/intc_pkg.sv
// Shared definitions for the fixed-priority interrupt controller:
// register word offsets, FSM state encoding and source index constants.
package intc_pkg;

  localparam int unsigned INTC_NUM_SRC = 4;
  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned DATA_W       = 32;

  // Source indices; lowest index is highest priority.
  localparam int unsigned SRC_EXT1 = 0;
  localparam int unsigned SRC_EXT2 = 1;
  localparam int unsigned SRC_TIM1 = 2;
  localparam int unsigned SRC_TIM2 = 3;

  // Register word offsets.
  localparam logic [ADDR_W-1:0] REG_ENABLE  = 2'd0;
  localparam logic [ADDR_W-1:0] REG_PENDING = 2'd1;
  localparam logic [ADDR_W-1:0] REG_ACTIVE  = 2'd2;
  localparam logic [ADDR_W-1:0] REG_TRIGGER = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_ACTIVE  = 2'd2
  } intc_state_e;

endpackage

// File: rtl/intc_edge_detect.sv
// Rising-edge detector for one interrupt source.
// Optional feature: define INTC_SYNC_EN to insert a 2-flop synchronizer
// ahead of the edge register (adds 2 cycles of latency).
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   src_i    raw source line
//   pulse_c  one-cycle event pulse (combinational from the edge register)
module intc_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  output logic pulse_c
);

  logic src_s;
  logic prev_q, prev_d;

`ifdef INTC_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], src_i};

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= sync_d;
  end

  assign src_s = sync_q[1];
`else
  assign src_s = src_i;
`endif

  assign prev_d = src_s;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign pulse_c = src_s & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: latches source edges into PENDING,
// masks with ENABLE and presents one request at a time to the core through
// a req/ack/done handshake. Configured through a 4-word register window.
// Optional feature: INTC_SYNC_EN (source synchronizers, see intc_edge_detect).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   src_in[NUM_SRC]            raw interrupt sources, rising edge = event
//   bus_addr/wdata/we/re       register access (0 ENABLE,1 PENDING,2 ACTIVE,3 TRIGGER)
//   bus_rdata                  read data, one cycle after bus_re
//   irq_req, irq_id            request and source ID to the core
//   irq_ack, irq_done          core took the request / handler returned
module interrupt_controller
  import intc_pkg::*;
#(
  parameter  int unsigned NUM_SRC = INTC_NUM_SRC,
  localparam int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  src_in,
  input  logic [ADDR_W-1:0]   bus_addr,
  input  logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_we,
  input  logic                bus_re,
  output logic [DATA_W-1:0]   bus_rdata,
  output logic                irq_req,
  output logic [ID_W-1:0]     irq_id,
  input  logic                irq_ack,
  input  logic                irq_done
);

  logic [NUM_SRC-1:0] evt_c;

  intc_state_e        state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               req_q, req_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [NUM_SRC-1:0] masked_c;
  logic [ID_W-1:0]    win_id_c;
  logic [NUM_SRC-1:0] wdata_src_c;
  logic [NUM_SRC-1:0] set_c, clr_c;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_edge
    intc_edge_detect u_edge (
      .clk     (clk),
      .reset   (reset),
      .src_i   (src_in[gi]),
      .pulse_c (evt_c[gi])
    );
  end

  assign masked_c    = pending_q & enable_q;
  assign wdata_src_c = bus_wdata[NUM_SRC-1:0];

  // Priority encoder: lowest set index wins.
  always_comb begin
    win_id_c = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (masked_c[i]) win_id_c = ID_W'(i);
    end
  end

  // Next-state, register file and output logic.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    enable_d = enable_q;
    clr_c    = '0;
    set_c    = evt_c;
    rdata_d  = '0;

    if (bus_we && bus_addr == REG_ENABLE)  enable_d = wdata_src_c;
    if (bus_we && bus_addr == REG_PENDING) clr_c    = wdata_src_c;
    if (bus_we && bus_addr == REG_TRIGGER) set_c    = set_c | wdata_src_c;

    case (state_q)
      ST_IDLE: begin
        if (|masked_c) begin
          id_d    = win_id_c;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        // Ack wins over a same-cycle withdraw.
        if (irq_ack) begin
          clr_c[id_q] = 1'b1;
          state_d     = ST_ACTIVE;
        end else if (!pending_q[id_q] || !enable_q[id_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (irq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Set wins over a same-cycle clear.
    pending_d = (pending_q & ~clr_c) | set_c;
    req_d     = (state_d == ST_REQUEST);

    // Reads return pre-write values.
    if (bus_re) begin
      case (bus_addr)
        REG_ENABLE:  rdata_d[NUM_SRC-1:0] = enable_q;
        REG_PENDING: rdata_d[NUM_SRC-1:0] = pending_q;
        REG_ACTIVE: begin
          rdata_d[DATA_W-1] = (state_q == ST_ACTIVE);
          rdata_d[ID_W-1:0] = id_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      id_q      <= '0;
      req_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      id_q      <= id_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign irq_req   = req_q;
  assign irq_id    = id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with
// constant expectations plus a randomized run against a behavioural model.
module tb_interrupt_controller;

`ifdef INTC_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = SYNC ? 4 : 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_in;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we, bus_re;
  logic [31:0] bus_rdata;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic        irq_ack, irq_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [3:0]  m_en, m_pend, m_hist, m_s1, m_s2;
  int          m_mode;   // 0 nothing outstanding, 1 waiting for ack, 2 in handler
  logic [1:0]  m_id;
  logic        m_req;
  logic [31:0] m_rd;

  interrupt_controller dut (
    .clk(clk), .reset(reset), .src_in(src_in),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .irq_req(irq_req), .irq_id(irq_id),
    .irq_ack(irq_ack), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model of one clock edge, applied to the inputs held across that edge.
  task automatic model_step();
    logic [3:0] s_cur, evt, clr, set, masked, wd;
    if (reset) begin
      m_en = 0; m_pend = 0; m_hist = 0; m_s1 = 0; m_s2 = 0;
      m_mode = 0; m_id = 0; m_req = 0; m_rd = 0;
      return;
    end
    if (SYNC != 0) begin
      s_cur = m_s2; m_s2 = m_s1; m_s1 = src_in;
    end else begin
      s_cur = src_in;
    end
    evt    = s_cur & ~m_hist;
    m_hist = s_cur;
    wd     = bus_wdata[3:0];
    m_rd   = 0;
    if (bus_re) begin
      if (bus_addr == 2'd0) m_rd = {28'd0, m_en};
      if (bus_addr == 2'd1) m_rd = {28'd0, m_pend};
      if (bus_addr == 2'd2) m_rd = ((m_mode == 2) ? 32'h8000_0000 : 32'd0) | {30'd0, m_id};
    end
    clr = 0;
    set = evt;
    if (bus_we && bus_addr == 2'd1) clr = wd;
    if (bus_we && bus_addr == 2'd3) set = set | wd;
    masked = m_pend & m_en;
    if (m_mode == 0) begin
      if (masked != 0) begin
        for (int i = 3; i >= 0; i--) if (masked[i]) m_id = 2'(i);
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (irq_ack) begin
        m_mode = 2;
        clr[m_id] = 1'b1;
      end else if (!m_pend[m_id] || !m_en[m_id]) begin
        m_mode = 0;
      end
    end else begin
      if (irq_done) m_mode = 0;
    end
    m_pend = (m_pend & ~clr) | set;
    if (bus_we && bus_addr == 2'd0) m_en = wd;
    m_req = (m_mode == 1);
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later,
  // single-cycle strobes dropped afterwards.
  task automatic clk1();
    @(posedge clk);
    model_step();
    #1;
    bus_we = 0; bus_re = 0; irq_ack = 0; irq_done = 0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1;
    clk1();
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] r);
    bus_addr = a; bus_re = 1;
    clk1();
    r = bus_rdata;
  endtask

  task automatic do_reset();
    reset = 1;
    clk1();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    src_in = 0; bus_addr = 0; bus_wdata = 0; bus_we = 0; bus_re = 0;
    irq_ack = 0; irq_done = 0; reset = 1;
    clk1(); clk1();
    reset = 0;
    checks++;
    if (irq_req !== 1'b0 || irq_id !== 2'd0 || bus_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b id=%0d rdata=%h, want 0 0 0", irq_req, irq_id, bus_rdata);
    end
    do_read(2'd0, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL reset_enable: got %h want 0", r); end
    do_read(2'd1, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h want 0", r); end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    do_reset();
    do_write(2'd0, 32'hF);
    src_in = 4'b0100;
    for (int i = 0; i < LAT - 1; i++) clk1();
    checks++;
    if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_early: req=%b want 0", irq_req); end
    clk1();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd2) begin
      errors++; $display("FAIL basic_req: req=%b id=%0d want 1 2", irq_req, irq_id);
    end
    src_in = 0;
    irq_ack = 1;
    clk1();
    checks++;
    if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_ack_req: req=%b want 0", irq_req); end
    do_read(2'd1, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL basic_pending: got %h want 0", r); end
    do_read(2'd2, r);
    checks++;
    if (r !== 32'h8000_0002) begin errors++; $display("FAIL basic_active: got %h want 80000002", r); end
    do_read(2'd3, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL trigger_read: got %h want 0", r); end
    irq_done = 1;
    clk1();
    do_read(2'd2, r);
    checks++;
    if (r !== 32'h0000_0002 || irq_req !== 1'b0) begin
      errors++; $display("FAIL basic_done: active=%h req=%b want 00000002 0", r, irq_req);
    end
  endtask

  task automatic test_priority();
    do_reset();
    do_write(2'd0, 32'hF);
    src_in = 4'b1010;
    for (int i = 0; i < LAT; i++) clk1();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
      errors++; $display("FAIL prio_first: req=%b id=%0d want 1 1", irq_req, irq_id);
    end
    src_in = 0;
    irq_ack = 1; clk1();
    clk1();
    irq_done = 1; clk1();
    checks++;
    if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_done1: req=%b want 0", irq_req); end
    clk1();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd3) begin
      errors++; $display("FAIL prio_second: req=%b id=%0d want 1 3", irq_req, irq_id);
    end
    irq_ack = 1; clk1();
    irq_done = 1; clk1();
  endtask

  task automatic test_withdraw();
    logic [31:0] r;
    do_reset();
    do_write(2'd0, 32'hF);
    src_in = 4'b0100;
    for (int i = 0; i < LAT; i++) clk1();
    src_in = 0;
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd2) begin
      errors++; $display("FAIL wd_req: req=%b id=%0d want 1 2", irq_req, irq_id);
    end
    do_write(2'd0, 32'hB);
    checks++;
    if (irq_req !== 1'b1) begin errors++; $display("FAIL wd_hold: req=%b want 1", irq_req); end
    do_read(2'd1, r);
    checks++;
    if (irq_req !== 1'b0 || r !== 32'h4) begin
      errors++; $display("FAIL wd_drop: req=%b pending=%h want 0 4", irq_req, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic        seen;
    do_reset();
    do_write(2'd0, 32'h1);
    if (SYNC != 0) src_in = 4'b0001;
    do_write(2'd3, 32'h1);
    clk1();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd0) begin
      errors++; $display("FAIL trig_req: req=%b id=%0d want 1 0", irq_req, irq_id);
    end
    src_in = 4'b0001;
    irq_ack = 1;
    clk1();
    do_read(2'd1, r);
    checks++;
    if (r !== 32'h1 || irq_req !== 1'b0) begin
      errors++; $display("FAIL ack_set_race: pending=%h req=%b want 1 0", r, irq_req);
    end
    do_read(2'd2, r);
    checks++;
    if (r !== 32'h8000_0000) begin errors++; $display("FAIL active_id0: got %h want 80000000", r); end
    src_in = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) irq_ack = 1;
      clk1();
      if (irq_req) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL no_nesting: req seen=%b want 0", seen); end
    irq_done = 1; clk1();
    clk1();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd0) begin
      errors++; $display("FAIL rerequest: req=%b id=%0d want 1 0", irq_req, irq_id);
    end
    irq_ack = 1; clk1();
    irq_done = 1; clk1();
    irq_ack = 1; clk1();
    clk1();
    do_read(2'd2, r);
    checks++;
    if (r !== 32'h0 || irq_req !== 1'b0) begin
      errors++; $display("FAIL spurious_ack: active=%h req=%b want 0 0", r, irq_req);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    do_reset();
    do_write(2'd0, 32'hF);
    do_write(2'd3, 32'hC);
    clk1();
    irq_ack = 1; clk1();
    do_reset();
    checks++;
    if (irq_req !== 1'b0 || irq_id !== 2'd0) begin
      errors++; $display("FAIL rst_mid_out: req=%b id=%0d want 0 0", irq_req, irq_id);
    end
    do_read(2'd2, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL rst_mid_active: got %h want 0", r); end
    do_read(2'd0, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL rst_mid_enable: got %h want 0", r); end
    do_read(2'd1, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL rst_mid_pending: got %h want 0", r); end
  endtask

  task automatic test_random();
    logic was_re;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) src_in[b] = ~src_in[b];
      bus_addr  = 2'($urandom_range(0, 3));
      bus_wdata = $urandom;
      bus_we    = ($urandom_range(0, 7) == 0);
      bus_re    = ($urandom_range(0, 3) == 0);
      irq_ack   = ($urandom_range(0, 2) == 0);
      irq_done  = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      was_re    = bus_re;
      clk1();
      reset = 0;
      checks++;
      if (irq_req !== m_req || irq_id !== m_id) begin
        errors++;
        $display("FAIL rand_irq cycle %0d: req=%b id=%0d want %b %0d", n, irq_req, irq_id, m_req, m_id);
      end
      if (was_re) begin
        checks++;
        if (bus_rdata !== m_rd) begin
          errors++;
          $display("FAIL rand_rdata cycle %0d: got %h want %h", n, bus_rdata, m_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Fixed-priority interrupt controller that sits between the microcontroller's interrupt sources (int_ext1, int_ext2, TIM1 and TIM2 compare events) and the CPU core. It latches source edges into a pending register and masks them with an enable register. It presents one request at a time to the core through a request/ack/done handshake. The CPU configures it through a small memory-mapped register window.

## Interface
- NUM_SRC, 4, number of sources; index 0 = int_ext1, 1 = int_ext2, 2 = tim1_cmp, 3 = tim2_cmp; lowest index = highest priority
- ID_W, 2, width of irq_id, equal to clog2(NUM_SRC)

- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- src_in  in  NUM_SRC  raw interrupt source lines; rising edge = event
- bus_addr  in  2  word address: 0 ENABLE, 1 PENDING, 2 ACTIVE, 3 TRIGGER
- bus_wdata  in  32  write data; bits [NUM_SRC-1:0] used
- bus_we  in  1  write strobe, one cycle
- bus_re  in  1  read strobe, one cycle
- bus_rdata  out  32  read data, valid the cycle after bus_re; unused bits 0
- irq_req  out  1  interrupt request to core
- irq_id  out  ID_W  source ID of the current request or active interrupt
- irq_ack  in  1  one-cycle pulse: core has taken the request
- irq_done  in  1  one-cycle pulse: handler returned (mret)

## Operation
- Reset: enable=0, pending=0, edge history=0, state IDLE, irq_req=0, irq_id=0, bus_rdata=0.
- Edge detect: event[i] = src[i] & ~src_prev[i]. The event sets pending[i] on the next edge.
- Pending clear sources: write-1-to-clear at PENDING, and irq_ack for the latched ID. Set has priority over a same-cycle clear of the same bit.
- TRIGGER write: writing 1 to a bit sets pending for that bit (software interrupt). Reads of TRIGGER return 0.
- ENABLE: read/write. Masking never clears pending.
- ACTIVE read: bit 31 = state is ACTIVE; [ID_W-1:0] = irq_id.
- FSM states:
  - IDLE:
    - If any (pending & enable) is set: latch irq_id = lowest set index, go to REQUEST.
  - REQUEST:
    - irq_req=1. irq_id is frozen; a higher-priority arrival does not replace it.
    - On irq_ack: clear pending[irq_id], go to ACTIVE.
    - If pending[irq_id] or enable[irq_id] drops before ack: withdraw and go to IDLE.
    - Ack wins over a same-cycle withdraw.
  - ACTIVE:
    - irq_req=0. No nesting; new events only accumulate in pending.
    - On irq_done: go to IDLE.
- Ignored inputs: irq_ack outside REQUEST; irq_done outside ACTIVE.
- Re-assertion of a source while it is ACTIVE sets its pending bit again; it is serviced after done.
- Writes to addresses that are not writable (ACTIVE) are ignored. Simultaneous bus_we and bus_re: both take effect; the read returns the pre-write value.

## Timing
- Source edge sampled at edge t: pending at t+1, irq_req=1 at t+2 (plus 2 with INTC_SYNC_EN).
- irq_ack at edge t: irq_req=0 and pending bit cleared from t+1.
- irq_done at edge t: IDLE at t+1. A further request can be raised at t+2.
- Bus read latency 1 cycle. Bus write takes effect at the strobe edge; its effect on the FSM is visible 1 cycle later.
- Reset asserted mid-request or mid-active: everything returns to reset values at the next edge. Any interrupt in flight is dropped.

## Configuration
- INTC_SYNC_EN defined: each src_in passes through a 2-flop synchronizer before edge detection. Source-to-irq_req latency becomes 4 cycles.
- INTC_SYNC_EN undefined: src_in is assumed synchronous to clk and used directly. Latency is 2 cycles.

## Structure
- Shared package intc_pkg holds:
  - register word offsets (ENABLE, PENDING, ACTIVE, TRIGGER)
  - FSM state enum (IDLE, REQUEST, ACTIVE)
  - default NUM_SRC and source index constants
- One sub-module: intc_edge_detect, one instance per source. It contains the optional synchronizer plus the edge register and outputs a one-cycle event pulse.
- The priority encoder and FSM stay in the top module.

## Test plan
- Reset, enable=0xF, pulse src_in[2] -> irq_req=1 two cycles later (four with sync), irq_id=2; irq_ack -> PENDING reads 0x0, ACTIVE reads 0x80000002.
- Edges on src 3 and src 1 in the same cycle -> irq_id=1. After ack+done -> irq_id=3 is requested at done+2.
- In REQUEST for id 2, write ENABLE=0xB -> irq_req drops the next cycle, PENDING still reads 0x4.
- Write TRIGGER=0x1 with enable=0x1 -> irq_id=0 requested; irq_ack and a same-cycle src_in[0] edge -> pending[0] stays 1.
- ACTIVE id 0 plus a new src 0 edge -> no irq_req until irq_done; then re-request id 0. Spurious irq_ack in IDLE -> no state change.
- Assert reset during ACTIVE -> next cycle irq_req=0, state IDLE, ENABLE and PENDING read 0.
